// File: rtl/fft_bfly_stream.sv
// Streaming radix-2 DIF butterfly: fft_a = a+b, fft_b = (a-b)*W16^k, with a
// 3-stage non-stalling datapath feeding a credit-protected fall-through FIFO.
module fft_bfly_stream #(
    parameter int DW    = 16,
    parameter int DEPTH = 4,
    parameter int TW    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2*DW-1:0] a,
    input  logic [2*DW-1:0] b,
    input  logic [2:0]      power,
    input  logic            scale,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [2*DW-1:0] fft_a,
    output logic [2*DW-1:0] fft_b,
    output logic            out_valid,
    input  logic            out_ready
);
    localparam int FRAC   = TW - 2;
    localparam int SW     = DW + 1;
    localparam int PW     = SW + TW;
    localparam int AW     = PW + 2;
    localparam int STAGES = 3;
    localparam int AWID   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW     = AWID + 1;

    // Twiddle magnitudes are kept at Q30 and rounded to FRAC bits at elaboration.
    function automatic logic signed [TW-1:0] tw_q(input longint v);
        longint r;
        r = (v + (longint'(1) <<< (29 - FRAC))) >>> (30 - FRAC);
        return TW'(r);
    endfunction

    localparam logic signed [TW-1:0] TC0 = tw_q(64'sd1073741824);
    localparam logic signed [TW-1:0] TC1 = tw_q(64'sd992008095);
    localparam logic signed [TW-1:0] TC2 = tw_q(64'sd759250125);
    localparam logic signed [TW-1:0] TC3 = tw_q(64'sd410903207);

    localparam logic signed [AW-1:0] RND  = AW'(longint'(1) <<< (FRAC - 1));
    localparam logic signed [AW-1:0] SMAX = AW'((longint'(1) <<< (DW - 1)) - 1);
    localparam logic signed [AW-1:0] SMIN = AW'(-(longint'(1) <<< (DW - 1)));

    function automatic logic signed [AW-1:0] halve(input logic signed [AW-1:0] v,
                                                   input logic en);
        return en ? ((v + AW'(1)) >>> 1) : v;
    endfunction

    function automatic logic [DW-1:0] sat(input logic signed [AW-1:0] v);
        if (v > SMAX)      return {1'b0, {(DW-1){1'b1}}};
        else if (v < SMIN) return {1'b1, {(DW-1){1'b0}}};
        else               return v[DW-1:0];
    endfunction

    logic signed [DW-1:0] a_re, a_im, b_re, b_im;
    assign a_re = a[2*DW-1:DW];
    assign a_im = a[DW-1:0];
    assign b_re = b[2*DW-1:DW];
    assign b_im = b[DW-1:0];

    logic [STAGES-1:0]    vld_pipe_q, vld_pipe_d;
    logic signed [SW-1:0] s1_sr_q, s1_si_q, s1_dr_q, s1_di_q;
    logic signed [SW-1:0] s1_sr_d, s1_si_d, s1_dr_d, s1_di_d;
    logic [2:0]           s1_pow_q, s1_pow_d;
    logic                 s1_scl_q, s1_scl_d;

    logic signed [SW-1:0] s2_sr_q, s2_si_q, s2_sr_d, s2_si_d;
    logic signed [PW-1:0] s2_rc_q, s2_rs_q, s2_ic_q, s2_is_q;
    logic signed [PW-1:0] s2_rc_d, s2_rs_d, s2_ic_d, s2_is_d;
    logic                 s2_scl_q, s2_scl_d;
    logic signed [TW-1:0] cos_w, sin_w;

    logic [2*DW-1:0]      s3_a_q, s3_b_q, s3_a_d, s3_b_d;
    logic signed [AW-1:0] ar_w, ai_w, br_w, bi_w;

    logic [DEPTH-1:0][4*DW-1:0] mem_q, mem_d;
    logic [AWID-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CW:0]          occ;
    logic                 acc, push, pop;
    logic [4*DW-1:0]      head;

    // Credit check counts every result that will eventually land in the FIFO.
    always_comb begin
        occ = (CW+1)'(cnt_q) + (CW+1)'(vld_pipe_q[0]) + (CW+1)'(vld_pipe_q[1])
            + (CW+1)'(vld_pipe_q[2]);
        in_ready  = !rst && (occ < (CW+1)'(DEPTH));
        out_valid = (cnt_q != '0);
        head      = mem_q[rd_ptr_q];
        fft_a     = out_valid ? head[4*DW-1:2*DW] : '0;
        fft_b     = out_valid ? head[2*DW-1:0]    : '0;
        acc       = in_valid && in_ready;
        push      = vld_pipe_q[STAGES-1];
        pop       = out_valid && out_ready;
    end

    always_comb begin
        vld_pipe_d = {vld_pipe_q[STAGES-2:0], acc};
        s1_sr_d    = SW'(a_re) + SW'(b_re);
        s1_si_d    = SW'(a_im) + SW'(b_im);
        s1_dr_d    = SW'(a_re) - SW'(b_re);
        s1_di_d    = SW'(a_im) - SW'(b_im);
        s1_pow_d   = power;
        s1_scl_d   = scale;
    end

    always_comb begin
        cos_w = '0;
        sin_w = '0;
        case (s1_pow_q)
            3'd0:    begin cos_w = TC0;  sin_w = '0;  end
            3'd1:    begin cos_w = TC1;  sin_w = TC3; end
            3'd2:    begin cos_w = TC2;  sin_w = TC2; end
            3'd3:    begin cos_w = TC3;  sin_w = TC1; end
            3'd4:    begin cos_w = '0;   sin_w = TC0; end
            3'd5:    begin cos_w = -TC3; sin_w = TC1; end
            3'd6:    begin cos_w = -TC2; sin_w = TC2; end
            default: begin cos_w = -TC1; sin_w = TC3; end
        endcase
        s2_rc_d  = PW'(s1_dr_q) * PW'(cos_w);
        s2_rs_d  = PW'(s1_dr_q) * PW'(sin_w);
        s2_ic_d  = PW'(s1_di_q) * PW'(cos_w);
        s2_is_d  = PW'(s1_di_q) * PW'(sin_w);
        s2_sr_d  = s1_sr_q;
        s2_si_d  = s1_si_q;
        s2_scl_d = s1_scl_q;
    end

    // Round half-up to FRAC, optional block scaling, then clamp to DW bits.
    always_comb begin
        br_w   = halve((AW'(s2_rc_q) + AW'(s2_is_q) + RND) >>> FRAC, s2_scl_q);
        bi_w   = halve((AW'(s2_ic_q) - AW'(s2_rs_q) + RND) >>> FRAC, s2_scl_q);
        ar_w   = halve(AW'(s2_sr_q), s2_scl_q);
        ai_w   = halve(AW'(s2_si_q), s2_scl_q);
        s3_a_d = {sat(ar_w), sat(ai_w)};
        s3_b_d = {sat(br_w), sat(bi_w)};
    end

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = {s3_a_q, s3_b_q};
        wr_ptr_d = wr_ptr_q + AWID'(push);
        rd_ptr_d = rd_ptr_q + AWID'(pop);
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q <= '0;
            s1_sr_q    <= '0;
            s1_si_q    <= '0;
            s1_dr_q    <= '0;
            s1_di_q    <= '0;
            s1_pow_q   <= '0;
            s1_scl_q   <= 1'b0;
            s2_sr_q    <= '0;
            s2_si_q    <= '0;
            s2_rc_q    <= '0;
            s2_rs_q    <= '0;
            s2_ic_q    <= '0;
            s2_is_q    <= '0;
            s2_scl_q   <= 1'b0;
            s3_a_q     <= '0;
            s3_b_q     <= '0;
            mem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            s1_sr_q    <= s1_sr_d;
            s1_si_q    <= s1_si_d;
            s1_dr_q    <= s1_dr_d;
            s1_di_q    <= s1_di_d;
            s1_pow_q   <= s1_pow_d;
            s1_scl_q   <= s1_scl_d;
            s2_sr_q    <= s2_sr_d;
            s2_si_q    <= s2_si_d;
            s2_rc_q    <= s2_rc_d;
            s2_rs_q    <= s2_rs_d;
            s2_ic_q    <= s2_ic_d;
            s2_is_q    <= s2_is_d;
            s2_scl_q   <= s2_scl_d;
            s3_a_q     <= s3_a_d;
            s3_b_q     <= s3_b_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fft_bfly_stream.sv
// Bench for fft_bfly_stream: directed vector table, backpressure, random
// stream against an arithmetic reference, and reset mid-operation.
module tb_fft_bfly_stream;
    localparam int DW = 16, DEPTH = 4, TW = 16;
    localparam int C_TAB [8] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137};
    localparam int S_TAB [8] = '{0, 6270, 11585, 15137, 16384, 15137, 11585, 6270};

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b, fft_a, fft_b;
    logic [2:0]  power;
    logic        scale, in_valid, in_ready, out_valid, out_ready;

    int n_chk = 0, n_fail = 0, n_acc = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        int ar, ai, br, bi;
        logic [2:0] pw;
        logic sc;
        int far, fai, fbr, fbi;
    } vec_t;
    vec_t vecs[10];

    fft_bfly_stream #(.DW(DW), .DEPTH(DEPTH), .TW(TW)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .power(power), .scale(scale),
        .in_valid(in_valid), .in_ready(in_ready), .fft_a(fft_a), .fft_b(fft_b),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] cx(input int re, input int im);
        logic [31:0] r, i;
        r = re;
        i = im;
        return {r[15:0], i[15:0]};
    endfunction

    function automatic logic [15:0] sat16(input longint v);
        logic [63:0] t;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        t = v;
        return t[15:0];
    endfunction

    function automatic longint half(input longint v, input logic en);
        return en ? ((v + 1) >>> 1) : v;
    endfunction

    function automatic logic [63:0] model(input logic [31:0] ai, input logic [31:0] bi,
                                          input logic [2:0] k, input logic sc);
        longint ar_, ai_, br_, bi_, dr, di, re, im, c, s;
        ar_ = longint'($signed(ai[31:16]));
        ai_ = longint'($signed(ai[15:0]));
        br_ = longint'($signed(bi[31:16]));
        bi_ = longint'($signed(bi[15:0]));
        c = C_TAB[k];
        s = S_TAB[k];
        dr = ar_ - br_;
        di = ai_ - bi_;
        re = half((dr * c + di * s + 8192) >>> 14, sc);
        im = half((di * c - dr * s + 8192) >>> 14, sc);
        return {sat16(half(ar_ + br_, sc)), sat16(half(ai_ + bi_, sc)), sat16(re), sat16(im)};
    endfunction

    function automatic logic [15:0] rnd_comp();
        case ($urandom % 8)
            0: return 16'h7fff;
            1: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic rand_inputs();
        a = {rnd_comp(), rnd_comp()};
        b = {rnd_comp(), rnd_comp()};
        power = 3'($urandom);
        scale = 1'($urandom);
    endtask

    // Scoreboard: inputs seen accepted go into the model queue; pops are compared.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, power, scale));
                n_acc++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL stream_extra: got %h expected no result at %0t",
                             {fft_a, fft_b}, $time);
                end else begin
                    chk("stream", {fft_a, fft_b}, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached with %0d results pending", exp_q.size());
        $fatal(1);
    end

    task automatic apply_vec(input int i);
        vec_t v;
        v = vecs[i];
        @(posedge clk); #1;
        a = cx(v.ar, v.ai);
        b = cx(v.br, v.bi);
        power = v.pw;
        scale = v.sc;
        in_valid = 1'b1;
        out_ready = 1'b1;
        chk($sformatf("v%0d_in_ready", i), in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk($sformatf("v%0d_early_valid", i), out_valid, 0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_out_valid", i), out_valid, 1);
        chk($sformatf("v%0d_fft_a", i), fft_a, cx(v.far, v.fai));
        chk($sformatf("v%0d_fft_b", i), fft_b, cx(v.fbr, v.fbi));
    endtask

    initial begin
        int base, cyc;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; power = '0; scale = 1'b0;
        out_ready = 1'b1;
        vecs[0] = '{100, 50, 20, 10, 3'd0, 1'b0, 120, 60, 80, 40};
        vecs[1] = '{100, 50, 20, 10, 3'd4, 1'b0, 120, 60, 40, -80};
        vecs[2] = '{16384, 0, 0, 0, 3'd2, 1'b0, 16384, 0, 11585, -11585};
        vecs[3] = '{32767, 0, 32767, 0, 3'd0, 1'b0, 32767, 0, 0, 0};
        vecs[4] = '{32767, 0, 32767, 0, 3'd0, 1'b1, 32767, 0, 0, 0};
        vecs[5] = '{32767, 0, -32768, 0, 3'd0, 1'b0, -1, 0, 32767, 0};
        vecs[6] = '{-32768, 0, 32767, 0, 3'd0, 1'b0, -1, 0, -32768, 0};
        vecs[7] = '{101, -51, 0, 0, 3'd0, 1'b1, 51, -25, 51, -25};
        vecs[8] = '{1000, 0, 0, 0, 3'd1, 1'b0, 1000, 0, 924, -383};
        vecs[9] = '{0, 1000, 0, 0, 3'd6, 1'b0, 0, 1000, 707, -707};

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fft_a", fft_a, 0);
        chk("rst_fft_b", fft_b, 0);
        chk("rst_in_ready", in_ready, 0);
        @(posedge clk); #1 rst = 1'b0;
        #1 chk("post_rst_in_ready", in_ready, 1);

        for (int i = 0; i < 10; i++) apply_vec(i);

        // Backpressure: only DEPTH inputs fit, then drain in order.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        rand_inputs();
        base = n_acc;
        repeat (12) begin
            @(posedge clk); #1;
            rand_inputs();
        end
        chk("bp_accepted", 64'(n_acc - base), DEPTH);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_hold_head", {fft_a, fft_b}, exp_q[0]);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_ready_after_pop", in_ready, 1);
        repeat (DEPTH) @(posedge clk);
        #1;
        chk("bp_drained", out_valid, 0);
        chk("bp_queue_empty", 64'(exp_q.size()), 0);

        // Random handshake stream of 1000 inputs.
        base = n_acc;
        cyc = 0;
        while (cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
            if (n_acc - base >= 1000) break;
            rand_inputs();
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("rand_accepted", 64'(n_acc - base), 1000);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rand_drained", 64'(exp_q.size()), 0);
        chk("rand_out_valid", out_valid, 0);

        // Reset with two results buffered and two still in the pipeline.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        rand_inputs();
        @(posedge clk); #1 rand_inputs();
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("mid_buffered", out_valid, 1);
        in_valid = 1'b1;
        rand_inputs();
        @(posedge clk); #1 rand_inputs();
        @(posedge clk); #1 in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_fft_a", fft_a, 0);
        chk("mid_rst_fft_b", fft_b, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        out_ready = 1'b1;
        #1 chk("mid_rel_in_ready", in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk($sformatf("mid_no_stale_%0d", i), out_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
